// File: rtl/multiword_add_sequencer.sv
// Purpose: runs one external WIDTH-bit adder over WORDS slices (LSB first) to form a WIDTH*WORDS-bit add/sub.
// Latency: WORDS+1 cycles from the accept cycle to out_valid; WORDS+2 cycles per operation.
// Backpressure: in_ready only in IDLE; the result holds in DONE until out_ready, and in_valid is ignored meanwhile.
module multiword_add_sequencer #(
  parameter int WIDTH = 32,
  parameter int WORDS = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH*WORDS-1:0] in_a,
  input  logic [WIDTH*WORDS-1:0] in_b,
  input  logic                   in_sub,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH*WORDS-1:0] out_sum,
  output logic                   out_cout,
  output logic                   out_ovf,
  output logic                   busy,
  output logic [WIDTH-1:0]       add_a,
  output logic [WIDTH-1:0]       add_b,
  output logic                   add_cin,
  input  logic [WIDTH-1:0]       add_sum,
  input  logic                   add_cout
);

  localparam int N    = WIDTH * WORDS;
  localparam int IDXW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WORDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [N-1:0]    a_q;
  logic [N-1:0]    b_q;      // already inverted for subtract
  logic [N-1:0]    sum_q;
  logic            carry_q;
  logic            cout_q;
  logic            ovf_q;
  logic [IDXW-1:0] idx_q;
  logic [31:0]     slice_base;

  assign slice_base = 32'(idx_q) * WIDTH;
  assign out_sum    = sum_q;
  assign out_cout   = cout_q;
  assign out_ovf    = ovf_q;

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state, handshake outputs and adder drive (adder inputs are zero outside RUN).
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    add_a     = '0;
    add_b     = '0;
    add_cin   = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = RUN;
      end
      RUN: begin
        busy    = 1'b1;
        add_a   = a_q[slice_base +: WIDTH];
        add_b   = b_q[slice_base +: WIDTH];
        add_cin = carry_q;
        if (idx_q == LAST_IDX) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture at accept, slice-by-slice result collection during RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      idx_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q     <= in_a;
            b_q     <= in_sub ? ~in_b : in_b;
            carry_q <= in_sub;
            idx_q   <= '0;
          end
        end
        RUN: begin
          sum_q[slice_base +: WIDTH] <= add_sum;
          carry_q                    <= add_cout;
          if (idx_q == LAST_IDX) begin
            // Top slice: final carry and signed overflow of the full-width op.
            cout_q <= add_cout;
            ovf_q  <= (a_q[N-1] == b_q[N-1]) && (add_sum[WIDTH-1] != a_q[N-1]);
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
